// File: rtl/operand_fetch_pkg.sv
// Shared constants, types and operand-select helper for the operand fetch stage.
package operand_fetch_pkg;

  localparam int DATA_W   = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 1 << ADDR_W;

  typedef logic [DATA_W-1:0] data_t;
  typedef logic [ADDR_W-1:0] addr_t;

  localparam addr_t REG_ZERO = '0;

  typedef struct packed {
    data_t a;
    data_t b;
    data_t rs2_val;
    addr_t rd;
    logic  reg_write;
  } fetch_bundle_t;

  // x0 reads as zero; a writeback landing this edge overrides the stale file data.
  function automatic data_t read_operand(addr_t rs, logic wb_write, addr_t wb_addr,
                                         data_t wb_data, data_t rf_data);
    if (rs == REG_ZERO)
      return '0;
    else if (wb_write && (wb_addr == rs))
      return wb_data;
    else
      return rf_data;
  endfunction

endpackage

// File: rtl/operand_fetch_if.sv
// Decode-side and execute-side handshakes of the operand fetch stage.
interface operand_fetch_if;
  import operand_fetch_pkg::*;

  logic  in_valid;
  logic  in_ready;
  addr_t in_rs1;
  addr_t in_rs2;
  logic  in_use_rs1;
  logic  in_use_rs2;
  addr_t in_rd;
  logic  in_reg_write;
  data_t in_imm;
  logic  in_use_imm;

  logic  out_valid;
  logic  out_ready;
  data_t out_a;
  data_t out_b;
  data_t out_rs2_val;
  addr_t out_rd;
  logic  out_reg_write;

  modport master (
    output in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_reg_write,
           in_imm, in_use_imm, out_ready,
    input  in_ready, out_valid, out_a, out_b, out_rs2_val, out_rd, out_reg_write
  );

  modport slave (
    input  in_valid, in_rs1, in_rs2, in_use_rs1, in_use_rs2, in_rd, in_reg_write,
           in_imm, in_use_imm, out_ready,
    output in_ready, out_valid, out_a, out_b, out_rs2_val, out_rd, out_reg_write
  );

endinterface

// File: rtl/operand_fetch_hazard_scoreboard.sv
// Pending-write scoreboard and RAW/WAW hazard detection for the operand fetch stage.
module hazard_scoreboard
  import operand_fetch_pkg::*;
(
  input  logic                clk,
  input  logic                rst,
  input  logic                set_en_i,
  input  addr_t               set_addr_i,
  input  logic                clr_en_i,
  input  addr_t               clr_addr_i,
  input  addr_t               rs1_i,
  input  addr_t               rs2_i,
  input  logic                use_rs1_i,
  input  logic                use_rs2_i,
  input  addr_t               rd_i,
  input  logic                reg_write_i,
  output logic [NUM_REGS-1:0] pend_o,
  output logic                hz1_o,
  output logic                hz2_o,
  output logic                hzw_o
);

  logic [NUM_REGS-1:0] pend_q, pend_d;

  // A register retiring on this edge is no longer an obstacle.
  function automatic logic unresolved(logic [NUM_REGS-1:0] pend, addr_t r,
                                      logic clr_en, addr_t clr_addr);
    return (r != REG_ZERO) && pend[r] && !(clr_en && (clr_addr == r));
  endfunction

  assign hz1_o  = use_rs1_i   && unresolved(pend_q, rs1_i, clr_en_i, clr_addr_i);
  assign hz2_o  = use_rs2_i   && unresolved(pend_q, rs2_i, clr_en_i, clr_addr_i);
  assign hzw_o  = reg_write_i && unresolved(pend_q, rd_i,  clr_en_i, clr_addr_i);
  assign pend_o = pend_q;

  // Set is applied after clear so a new writer wins over the retiring one.
  always_comb begin
    pend_d = pend_q;
    if (clr_en_i && (clr_addr_i != REG_ZERO))
      pend_d[clr_addr_i] = 1'b0;
    if (set_en_i && (set_addr_i != REG_ZERO))
      pend_d[set_addr_i] = 1'b1;
    pend_d[REG_ZERO] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (rst)
      pend_q <= '0;
    else
      pend_q <= pend_d;
  end

endmodule

// File: rtl/operand_fetch.sv
// Register-read stage: drives register-file addresses, bypasses writeback,
// stalls on RAW/WAW hazards and buffers one operand bundle for execute.
module operand_fetch
  import operand_fetch_pkg::*;
(
  input  logic  clk,
  input  logic  rst,
  operand_fetch_if.slave bus,
  output addr_t R_Addr_A,
  output addr_t R_Addr_B,
  input  data_t R_Data_A,
  input  data_t R_Data_B,
  input  logic  wb_write,
  input  addr_t wb_addr,
  input  data_t wb_data
);

  logic                hz1, hz2, hzw, hazard, accept;
  logic [NUM_REGS-1:0] pend;
  data_t               rs1_val, rs2_val;
  fetch_bundle_t       buf_q, buf_d;
  logic                out_valid_q, out_valid_d;

  assign R_Addr_A = bus.in_rs1;
  assign R_Addr_B = bus.in_rs2;

  hazard_scoreboard u_scoreboard (
    .clk         (clk),
    .rst         (rst),
    .set_en_i    (accept && bus.in_reg_write),
    .set_addr_i  (bus.in_rd),
    .clr_en_i    (wb_write),
    .clr_addr_i  (wb_addr),
    .rs1_i       (bus.in_rs1),
    .rs2_i       (bus.in_rs2),
    .use_rs1_i   (bus.in_use_rs1),
    .use_rs2_i   (bus.in_use_rs2),
    .rd_i        (bus.in_rd),
    .reg_write_i (bus.in_reg_write),
    .pend_o      (pend),
    .hz1_o       (hz1),
    .hz2_o       (hz2),
    .hzw_o       (hzw)
  );

  assign hazard       = hz1 || hz2 || hzw;
  assign bus.in_ready = !hazard && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  assign rs1_val = read_operand(bus.in_rs1, wb_write, wb_addr, wb_data, R_Data_A);
  assign rs2_val = read_operand(bus.in_rs2, wb_write, wb_addr, wb_data, R_Data_B);

  always_comb begin
    buf_d       = buf_q;
    out_valid_d = out_valid_q;
    if (accept) begin
      buf_d.a         = rs1_val;
      buf_d.b         = bus.in_use_imm ? bus.in_imm : rs2_val;
      buf_d.rs2_val   = rs2_val;
      buf_d.rd        = bus.in_rd;
      buf_d.reg_write = bus.in_reg_write;
      out_valid_d     = 1'b1;
    end else if (bus.out_ready) begin
      out_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      buf_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      buf_q       <= buf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.out_valid     = out_valid_q;
  assign bus.out_a         = buf_q.a;
  assign bus.out_b         = buf_q.b;
  assign bus.out_rs2_val   = buf_q.rs2_val;
  assign bus.out_rd        = buf_q.rd;
  assign bus.out_reg_write = buf_q.reg_write;

  a_x0_never_pending: assert property (@(posedge clk) disable iff (rst) !pend[REG_ZERO]);

endmodule

// File: tb/tb_operand_fetch.sv
// Self-checking bench for operand_fetch: vector table plus stall and reset sequences,
// with an expected-output queue popped whenever execute consumes a bundle.
module tb_operand_fetch;
  import operand_fetch_pkg::*;

  logic  clk = 1'b0;
  logic  rst;
  addr_t R_Addr_A, R_Addr_B;
  data_t R_Data_A, R_Data_B;
  logic  wb_write;
  addr_t wb_addr;
  data_t wb_data;

  operand_fetch_if bus();

  operand_fetch dut (
    .clk      (clk),
    .rst      (rst),
    .bus      (bus.slave),
    .R_Addr_A (R_Addr_A),
    .R_Addr_B (R_Addr_B),
    .R_Data_A (R_Data_A),
    .R_Data_B (R_Data_B),
    .wb_write (wb_write),
    .wb_addr  (wb_addr),
    .wb_data  (wb_data)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic  valid;
    addr_t rs1, rs2;
    logic  u1, u2;
    addr_t rd;
    logic  rw;
    data_t imm;
    logic  ui;
    data_t rda, rdb;
    logic  wbw;
    addr_t wba;
    data_t wbd;
    logic  exp_ready;
    data_t exp_a, exp_b, exp_s2;
  } vec_t;

  int checks = 0;
  int passed = 0;
  int pushes = 0;
  int pops   = 0;
  fetch_bundle_t exp_q[$];
  vec_t vecs[15];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  function automatic vec_t mk(logic [31:0] valid, logic [31:0] rs1, logic [31:0] rs2,
                              logic [31:0] u1, logic [31:0] u2, logic [31:0] rd,
                              logic [31:0] rw, logic [31:0] imm, logic [31:0] ui,
                              logic [31:0] rda, logic [31:0] rdb, logic [31:0] wbw,
                              logic [31:0] wba, logic [31:0] wbd, logic [31:0] er,
                              logic [31:0] ea, logic [31:0] eb, logic [31:0] es2);
    vec_t v;
    v.valid = valid[0]; v.rs1 = addr_t'(rs1); v.rs2 = addr_t'(rs2);
    v.u1 = u1[0]; v.u2 = u2[0]; v.rd = addr_t'(rd); v.rw = rw[0];
    v.imm = imm; v.ui = ui[0]; v.rda = rda; v.rdb = rdb;
    v.wbw = wbw[0]; v.wba = addr_t'(wba); v.wbd = wbd;
    v.exp_ready = er[0]; v.exp_a = ea; v.exp_b = eb; v.exp_s2 = es2;
    return v;
  endfunction

  task automatic apply(vec_t v);
    bus.in_valid = v.valid; bus.in_rs1 = v.rs1; bus.in_rs2 = v.rs2;
    bus.in_use_rs1 = v.u1; bus.in_use_rs2 = v.u2; bus.in_rd = v.rd;
    bus.in_reg_write = v.rw; bus.in_imm = v.imm; bus.in_use_imm = v.ui;
    R_Data_A = v.rda; R_Data_B = v.rdb;
    wb_write = v.wbw; wb_addr = v.wba; wb_data = v.wbd;
  endtask

  task automatic push(data_t a, data_t b, data_t s2, addr_t rd, logic rw);
    fetch_bundle_t e;
    e.a = a; e.b = b; e.rs2_val = s2; e.rd = rd; e.reg_write = rw;
    exp_q.push_back(e);
    pushes++;
  endtask

  task automatic step_ready(string name, logic exp_ready);
    @(negedge clk);
    chk(name, {31'b0, bus.in_ready}, {31'b0, exp_ready});
    @(posedge clk); #1;
  endtask

  task automatic step();
    @(negedge clk);
    @(posedge clk); #1;
  endtask

  task automatic idle();
    apply(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    bus.out_ready = 1'b1;
  endtask

  // Execute side: compare each consumed bundle with the oldest expectation.
  always @(negedge clk) begin
    if (rst === 1'b0 && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        $display("FAIL unexpected_output: got out_a %h with no expected bundle", bus.out_a);
      end else begin
        fetch_bundle_t e;
        e = exp_q.pop_front();
        pops++;
        chk("out_a", bus.out_a, e.a);
        chk("out_b", bus.out_b, e.b);
        chk("out_rs2_val", bus.out_rs2_val, e.rs2_val);
        chk("out_rd", {27'b0, bus.out_rd}, {27'b0, e.rd});
        chk("out_reg_write", {31'b0, bus.out_reg_write}, {31'b0, e.reg_write});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = mk(1, 3, 4, 1, 1, 0, 0, 0, 0, 32'h11, 32'h22, 0, 0, 0, 1, 32'h11, 32'h22, 32'h22);
    vecs[1]  = mk(1, 0, 4, 1, 1, 0, 0, 32'h7FF, 1, 32'hDEADBEEF, 32'h44, 0, 0, 0, 1, 0, 32'h7FF, 32'h44);
    vecs[2]  = mk(1, 1, 2, 1, 1, 5, 1, 0, 0, 1, 2, 0, 0, 0, 1, 1, 2, 2);
    vecs[3]  = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[4]  = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[5]  = mk(1, 5, 0, 1, 0, 0, 0, 0, 0, 32'h99, 0, 1, 5, 32'hCAFE, 1, 32'hCAFE, 0, 0);
    vecs[6]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 32'h5A5A, 32'hA5A5, 0, 0, 0, 1, 0, 0, 0);
    vecs[7]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[8]  = mk(1, 0, 0, 0, 0, 7, 1, 0, 0, 0, 0, 1, 7, 32'h77, 1, 0, 0, 0);
    vecs[9]  = mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 32'h70, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[10] = mk(1, 7, 0, 1, 0, 0, 0, 0, 0, 32'h70, 0, 1, 7, 32'h1234, 1, 32'h1234, 0, 0);
    vecs[11] = mk(1, 0, 0, 1, 1, 0, 0, 0, 0, 32'h33, 32'h44, 1, 0, 32'h55, 1, 0, 0, 0);
    vecs[12] = mk(1, 6, 6, 1, 1, 0, 0, 0, 0, 32'h60, 32'h61, 1, 6, 32'hABC, 1, 32'hABC, 32'hABC, 32'hABC);
    vecs[13] = mk(1, 6, 6, 1, 1, 0, 0, 32'h123, 1, 32'h60, 32'h61, 0, 0, 0, 1, 32'h60, 32'h123, 32'h61);
    vecs[14] = mk(0, 5, 5, 1, 1, 5, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);

    rst = 1'b1;
    idle();
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("reset_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("reset_out_a", bus.out_a, 32'd0);
    chk("reset_out_b", bus.out_b, 32'd0);
    chk("reset_out_rs2_val", bus.out_rs2_val, 32'd0);
    chk("reset_out_rd", {27'b0, bus.out_rd}, 32'd0);
    chk("reset_out_reg_write", {31'b0, bus.out_reg_write}, 32'd0);
    chk("reset_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;

    for (int i = 0; i < 15; i++) begin
      apply(vecs[i]);
      chk($sformatf("raddr_a_%0d", i), {27'b0, R_Addr_A}, {27'b0, vecs[i].rs1});
      if (vecs[i].valid && vecs[i].exp_ready)
        push(vecs[i].exp_a, vecs[i].exp_b, vecs[i].exp_s2, vecs[i].rd, vecs[i].rw);
      step_ready($sformatf("vec_ready_%0d", i), vecs[i].exp_ready);
    end
    idle();
    step();

    // Execute back-pressure: buffer holds, decode stalls, then both drain in order.
    apply(mk(1, 8, 0, 1, 0, 10, 0, 0, 0, 32'h80, 0, 0, 0, 0, 1, 0, 0, 0));
    push(32'h80, 0, 0, 10, 0);
    step_ready("stall_first_ready", 1'b1);
    apply(mk(1, 9, 0, 1, 0, 11, 0, 0, 0, 32'h90, 0, 0, 0, 0, 0, 0, 0, 0));
    bus.out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk("stall_in_ready", {31'b0, bus.in_ready}, 32'd0);
      chk("stall_out_valid", {31'b0, bus.out_valid}, 32'd1);
      chk("stall_out_a", bus.out_a, 32'h80);
      chk("stall_out_rd", {27'b0, bus.out_rd}, 32'd10);
      @(posedge clk); #1;
    end
    bus.out_ready = 1'b1;
    push(32'h90, 0, 0, 11, 0);
    step_ready("stall_release_ready", 1'b1);
    idle();
    step();
    step();

    // Reset while a bundle is buffered and x9 is pending.
    apply(mk(1, 0, 0, 0, 0, 9, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    push(0, 0, 0, 9, 1);
    step_ready("rst_seq_writer_ready", 1'b1);
    apply(mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 32'h99, 0, 0, 0, 0, 0, 0, 0, 0));
    step_ready("rst_seq_raw_stall", 1'b0);
    apply(mk(1, 0, 0, 0, 0, 12, 0, 32'h42, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
    push(0, 32'h42, 0, 12, 0);
    step_ready("rst_seq_fill_ready", 1'b1);
    idle();
    bus.out_ready = 1'b0;
    rst = 1'b1;
    exp_q.delete();
    pushes--;
    step();
    rst = 1'b0;
    apply(mk(1, 9, 0, 1, 0, 0, 0, 0, 0, 32'h99, 0, 0, 0, 0, 1, 0, 0, 0));
    bus.out_ready = 1'b1;
    push(32'h99, 0, 0, 0, 0);
    @(negedge clk);
    chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    chk("midrst_out_a", bus.out_a, 32'd0);
    chk("midrst_out_b", bus.out_b, 32'd0);
    chk("midrst_out_rs2_val", bus.out_rs2_val, 32'd0);
    chk("midrst_out_rd", {27'b0, bus.out_rd}, 32'd0);
    chk("midrst_out_reg_write", {31'b0, bus.out_reg_write}, 32'd0);
    chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    @(posedge clk); #1;
    idle();

    for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
    step();
    chk("queue_drained", exp_q.size(), 32'd0);
    chk("pop_count", pops, pushes);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/operand_fetch.md
Name: operand_fetch

Overview:
- Register-read stage that sits directly upstream of the 32x32 register file and downstream of decode.
- Accepts one decoded instruction per cycle over a valid/ready handshake and drives the register-file read addresses combinationally.
- Captures the read data, after bypass and x0 handling, into a one-entry output buffer that feeds execute.
- Keeps a 32-bit pending-write scoreboard and stalls decode on RAW and WAW hazards against instructions that have not yet written back.

Parameters:
- DATA_W, 32, operand and immediate width
- ADDR_W, 5, register address width (32 registers)

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  decode offers an instruction
- in_ready  out  1  this stage accepts the instruction this cycle
- in_rs1  in  ADDR_W  source register 1
- in_rs2  in  ADDR_W  source register 2
- in_use_rs1  in  1  instruction reads rs1
- in_use_rs2  in  1  instruction reads rs2
- in_rd  in  ADDR_W  destination register
- in_reg_write  in  1  instruction writes rd
- in_imm  in  DATA_W  immediate
- in_use_imm  in  1  out_b takes in_imm instead of the rs2 value
- R_Addr_A  out  ADDR_W  register-file read address A; equals in_rs1, combinational
- R_Addr_B  out  ADDR_W  register-file read address B; equals in_rs2, combinational
- R_Data_A  in  DATA_W  register-file read data A (combinational read)
- R_Data_B  in  DATA_W  register-file read data B
- wb_write  in  1  writeback strobe, identical to the register-file Reg_Write
- wb_addr  in  ADDR_W  writeback address, identical to W_Addr
- wb_data  in  DATA_W  writeback data, identical to W_Data
- out_valid  out  1  buffered instruction valid
- out_ready  in  1  execute consumes the buffered instruction
- out_a  out  DATA_W  operand A
- out_b  out  DATA_W  operand B (register value or immediate)
- out_rs2_val  out  DATA_W  rs2 register value, for store data
- out_rd  out  ADDR_W  destination register
- out_reg_write  out  1  destination write enable

Behaviour:
- Reset: out_valid=0; out_a, out_b, out_rs2_val=0; out_rd=0; out_reg_write=0; scoreboard all zeros.
- Reset asserted mid-operation discards the buffered instruction and all pending bits.
- hz1 = in_use_rs1 & rs1!=0 & pend[rs1] & !(wb_write & wb_addr==rs1).
- hz2 is the same as hz1 using rs2.
- hzw = in_reg_write & rd!=0 & pend[rd] & !(wb_write & wb_addr==rd).
- hazard = hz1 | hz2 | hzw.
- in_ready = !hazard & (!out_valid | out_ready).
- in_ready is combinational and must not depend on in_valid.
- accept = in_valid & in_ready. On accept the buffer loads at the same edge.
- out_valid is asserted the next cycle, so latency is 1 cycle.
- Operand value per source, in priority order:
  - register 0 gives 0;
  - else wb_write & wb_addr==rs gives wb_data (same-edge write bypass);
  - else the register-file data.
- out_b = in_use_imm ? in_imm : the rs2 value. out_rs2_val always holds the rs2 value.
- Buffer update:
  - accept: load the new instruction.
  - No accept and out_ready: out_valid goes to 0.
  - Otherwise: hold, and all out_* stay stable while out_valid & !out_ready.
- Scoreboard set: pend[rd] is set on accept & in_reg_write & rd!=0.
- Scoreboard clear: pend[wb_addr] is cleared on wb_write & wb_addr!=0.
- If set and clear hit the same register on the same edge, set wins.
- Register 0 is never pending.
- The hzw stall guarantees at most one outstanding writer per register.
- Writes to register 0 on the writeback port are ignored by the scoreboard and by the bypass.
- Full throughput is one instruction per cycle when there are no hazards and out_ready=1.

Decomposition:
- Shared package holds:
  - constants ADDR_W, DATA_W and REG_ZERO=0;
  - a struct typedef for the buffered bundle (a, b, rs2_val, rd, reg_write).
- One sub-module, hazard_scoreboard, owns:
  - the 32-bit pend vector with its set/clear logic (set/clear ports in, pend vector out);
  - the hz1/hz2/hzw computation.

Test Plan:
- Reset, then in_valid=1, rs1=3, rs2=4, use both, R_Data_A=0x11, R_Data_B=0x22 -> next cycle out_valid=1, out_a=0x11, out_b=0x22; in_ready=1 throughout.
- rs1=0 with R_Data_A=0xDEADBEEF; use_imm=1, imm=0x7FF -> out_a=0, out_b=0x7FF, out_rs2_val equals the rs2 value.
- Issue rd=5 with reg_write, then an instruction reading rs1=5 -> in_ready=0 until wb_write, wb_addr=5, wb_data=0xCAFE.
- Continuing that case: in the wb cycle in_ready=1 and out_a=0xCAFE through the bypass, not R_Data_A.
- Issue rd=7 twice back-to-back -> second instruction stalls (WAW) until wb_addr=7.
- Same-edge set/clear: wb clears reg 7 while a new rd=7 instruction is accepted -> pend[7] stays 1.
- out_ready=0 for 3 cycles with a new in_valid -> in_ready=0 and out_* stable; then out_ready=1 -> back-to-back transfer, no loss or duplication.
- Assert rst while out_valid=1 and pend[9]=1 -> next cycle out_valid=0, outputs 0, and a read of rs1=9 is accepted immediately.
